// File: rtl/clk_period_meter_if.sv
// Signal bundle for clk_period_meter: the measured input and the period result.
// The meter uses the slave modport; whoever drives SIG_IN and consumes results uses master.
interface clk_period_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             stall;

  modport master (output sig_in, input period, valid, stall);
  modport slave  (input sig_in, output period, valid, stall);
endinterface

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous signal in fast-clock cycles (rise to rise).
// Define PERIOD_AVG_EN to report the average of the last four periods instead of the raw one.
module clk_period_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk_100mhz,
  input logic                rst_n,
  clk_period_meter_if.slave  bus
);

  localparam logic [0:0]       StIdle    = 1'b0;
  localparam logic [0:0]       StMeasure = 1'b1;
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic                   rise;
  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   stall_q, stall_d;

  assign rise = sync_q[SYNC_STAGES-1] & ~s_prev_q;

`ifdef PERIOD_AVG_EN
  // Three previous periods; the fourth history entry is the count being pushed now.
  logic [2:0][CNT_W-1:0] hist_q, hist_d;
  logic [1:0]            hist_cnt_q, hist_cnt_d;
  logic [CNT_W+1:0]      avg_sum;

  assign avg_sum = {2'b00, cnt_q} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
                 + {2'b00, hist_q[2]};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stall_d  = stall_q;
`ifdef PERIOD_AVG_EN
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (rise) begin
          cnt_d   = CntOne;
          state_d = StMeasure;
        end else begin
          cnt_d = '0;
        end
      end
      StMeasure: begin
        if (rise) begin
          cnt_d = CntOne;
`ifdef PERIOD_AVG_EN
          hist_d[0] = cnt_q;
          hist_d[1] = hist_q[0];
          hist_d[2] = hist_q[1];
          if (hist_cnt_q == 2'd3) begin
            period_d = avg_sum[CNT_W+1:2];
            valid_d  = 1'b1;
            stall_d  = 1'b0;
          end else begin
            hist_cnt_d = hist_cnt_q + 2'd1;
          end
`else
          period_d = cnt_q;
          valid_d  = 1'b1;
          stall_d  = 1'b0;
`endif
        end else if (cnt_q == CntMax) begin
          // Timeout: counter never wraps, measurement restarts from IDLE.
          stall_d  = 1'b1;
          period_d = '0;
          cnt_d    = '0;
          state_d  = StIdle;
`ifdef PERIOD_AVG_EN
          hist_d     = '0;
          hist_cnt_d = 2'd0;
`endif
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      s_prev_q <= sync_q[SYNC_STAGES-1];
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
    end
  end

`ifdef PERIOD_AVG_EN
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      hist_cnt_q <= 2'd0;
    end else begin
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end
`endif

  assign bus.period = period_q;
  assign bus.valid  = valid_q;
  assign bus.stall  = stall_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a 16-bit instance for period/reset tests and an
// 8-bit instance for the timeout test. Define PERIOD_AVG_EN to exercise the averaging build.
module tb_clk_period_meter;

  logic clk_100mhz;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  clk_period_meter_if #(.CNT_W(16)) bus16 ();
  clk_period_meter_if #(.CNT_W(8))  bus8 ();

  clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut16 (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .bus        (bus16.slave)
  );

  clk_period_meter #(.CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .bus        (bus8.slave)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // Record every VALID pulse with its period and cycle stamp; flag back-to-back pulses.
  int   q16[$];
  int   t16[$];
  int   dbl16;
  int   v8_cnt;
  logic v16_prev;

  always @(negedge clk_100mhz) begin
    if (bus16.valid) begin
      q16.push_back(int'(bus16.period));
      t16.push_back(cyc);
      if (v16_prev) dbl16 = dbl16 + 1;
    end
    v16_prev = bus16.valid;
    if (bus8.valid) v8_cnt = v8_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int get16(input int idx);
    if (idx < q16.size()) return q16[idx];
    return -1;
  endfunction

  task automatic clear_log();
    q16.delete();
    t16.delete();
    dbl16  = 0;
    v8_cnt = 0;
  endtask

  task automatic do_reset();
    bus16.sig_in = 1'b0;
    bus8.sig_in  = 1'b0;
    @(negedge clk_100mhz);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    rst_n = 1'b1;
    @(negedge clk_100mhz);
    clear_log();
  endtask

  // One square-wave period starting with a rise; sel 0 drives bus16, 1 drives bus8.
  task automatic square(input int sel, input int p);
    if (sel == 0) bus16.sig_in = 1'b1; else bus8.sig_in = 1'b1;
    repeat (p / 2) @(negedge clk_100mhz);
    if (sel == 0) bus16.sig_in = 1'b0; else bus8.sig_in = 1'b0;
    repeat (p - p / 2) @(negedge clk_100mhz);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    v16_prev     = 1'b0;
    rst_n        = 1'b1;
    bus16.sig_in = 1'b0;
    bus8.sig_in  = 1'b0;
    clear_log();

    do_reset();
    check("rst_period", 32'(bus16.period), 0);
    check("rst_valid", 32'(bus16.valid), 0);
    check("rst_stall", 32'(bus16.stall), 0);

`ifndef PERIOD_AVG_EN
    // Basic 2048-cycle square wave.
    square(0, 2048);
    check("basic_first_rise_no_valid", 32'(q16.size()), 0);
    repeat (3) square(0, 2048);
    check("basic_valid_count", 32'(q16.size()), 3);
    check("basic_period0", 32'(get16(0)), 2048);
    check("basic_period2", 32'(get16(2)), 2048);
    check("basic_spacing", 32'(t16.size() == 3 ? t16[2] - t16[1] : -1), 2048);
    check("basic_stall", 32'(bus16.stall), 0);
    check("basic_one_cycle_valid", 32'(dbl16), 0);

    // Period change: rises at 0, 2048, 2148, 2248.
    do_reset();
    square(0, 2048);
    square(0, 100);
    square(0, 100);
    square(0, 100);
    check("chg_count", 32'(q16.size()), 3);
    check("chg_p0", 32'(get16(0)), 2048);
    check("chg_p1", 32'(get16(1)), 100);
    check("chg_p2", 32'(get16(2)), 100);

    // Timeout on the 8-bit instance.
    do_reset();
    bus8.sig_in = 1'b1;
    repeat (5) @(negedge clk_100mhz);
    bus8.sig_in = 1'b0;
    repeat (195) @(negedge clk_100mhz);
    check("to_stall_early", 32'(bus8.stall), 0);
    repeat (70) @(negedge clk_100mhz);
    check("to_stall", 32'(bus8.stall), 1);
    check("to_period", 32'(bus8.period), 0);
    check("to_no_valid", 32'(v8_cnt), 0);
    square(1, 50);
    check("to_resume_stall_held", 32'(bus8.stall), 1);
    check("to_resume_no_valid", 32'(v8_cnt), 0);
    square(1, 50);
    check("to_resume_valid", 32'(v8_cnt), 1);
    check("to_resume_period", 32'(bus8.period), 50);
    check("to_resume_stall_clr", 32'(bus8.stall), 0);

    // Asynchronous reset 1000 cycles after a rise.
    do_reset();
    square(0, 2048);
    square(0, 2048);
    check("rmid_pre_period", 32'(bus16.period), 2048);
    bus16.sig_in = 1'b1;
    repeat (1000) @(negedge clk_100mhz);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_period_async", 32'(bus16.period), 0);
    check("rmid_valid_async", 32'(bus16.valid), 0);
    check("rmid_stall_async", 32'(bus16.stall), 0);
    repeat (24) @(negedge clk_100mhz);
    bus16.sig_in = 1'b0;
    repeat (10) @(negedge clk_100mhz);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_100mhz);
    clear_log();
    square(0, 2048);
    check("rmid_first_rise_no_valid", 32'(q16.size()), 0);
    square(0, 2048);
    check("rmid_valid_count", 32'(q16.size()), 1);
    check("rmid_period", 32'(get16(0)), 2048);

    // Minimum period: rise every other cycle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus16.sig_in = 1'b1;
      @(negedge clk_100mhz);
      bus16.sig_in = 1'b0;
      @(negedge clk_100mhz);
    end
    repeat (5) @(negedge clk_100mhz);
    check("min_count", 32'(q16.size()), 9);
    check("min_period_first", 32'(get16(0)), 2);
    check("min_period_last", 32'(get16(8)), 2);
    check("min_spacing", 32'(t16.size() >= 2 ? t16[1] - t16[0] : -1), 2);
`else
    // Averaging: raw periods 100, 100, 200, 200, 400.
    square(0, 100);
    square(0, 100);
    square(0, 200);
    square(0, 200);
    check("avg_no_valid_yet", 32'(q16.size()), 0);
    square(0, 400);
    check("avg_first_count", 32'(q16.size()), 1);
    check("avg_first", 32'(get16(0)), 150);
    square(0, 20);
    check("avg_second_count", 32'(q16.size()), 2);
    check("avg_second", 32'(get16(1)), 225);
    check("avg_one_cycle_valid", 32'(dbl16), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
